mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 36 +++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access_unit.sv | 111 +++++++++++
 tb/tb_mem_access_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions for the data-memory access stage: FSM states, func3
// size/sign encodings and the access legality rule.
package mem_access_unit_pkg;

  typedef logic [1:0] mau_state_t;

  localparam mau_state_t StIdle = 2'd0;
  localparam mau_state_t StReq  = 2'd1;
  localparam mau_state_t StDone = 2'd2;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  // Legal func3 for the direction, and address naturally aligned to the access size.
  function automatic logic access_legal(input logic is_load, input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    logic f3_ok;
    logic aligned;
    if (is_load) begin
      f3_ok = f3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU};
    end else begin
      f3_ok = f3 inside {F3Byte, F3Half, F3Word};
    end
    case (f3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b0;
    endcase
    return f3_ok & aligned;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the pipeline and a word-wide data memory: store lane
// replication and byte enables, load lane extraction with sign/zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        func3,
  input  logic [1:0]        addr_lo,
  input  logic              is_store,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be    = 4'b1111;
    wdata = wr_data;
    if (is_store) begin
      case (func3[1:0])
        2'b00: begin
          be    = 4'b0001 << addr_lo;
          wdata = {(DATA_W / 8){wr_data[7:0]}};
        end
        2'b01: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {(DATA_W / 16){wr_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = wr_data;
        end
      endcase
    end
  end

  always_comb begin
    load_data = rdata;
    case (func3)
      F3Byte:  load_data = {{(DATA_W - 8){byte_sel[7]}}, byte_sel};
      F3ByteU: load_data = {{(DATA_W - 8){1'b0}}, byte_sel};
      F3Half:  load_data = {{(DATA_W - 16){half_sel[15]}}, half_sel};
      F3HalfU: load_data = {{(DATA_W - 16){1'b0}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: stalls the pipeline while a single request is
// outstanding to data memory, with a bounded wait and an error pulse on bad access.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  mem_stall,
  output logic                  access_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  mau_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              req_any;
  logic              legal;
  logic              start;
  logic              in_req;
  logic              timed_out;
  logic [3:0]        lane_be;
  logic [DATA_W-1:0] load_data;

  assign req_any = MemRead | MemWrite;
  assign legal   = ~(MemRead & MemWrite) & access_legal(MemRead, func3, addr[1:0]);
  assign start   = (state_q == StIdle) & req_any & legal;
  assign in_req  = (state_q == StReq);
  // Counter stops at TIMEOUT, so reaching it in DONE identifies a timed-out access.
  assign timed_out = (state_q == StDone) & (cnt_q == CntW'(TIMEOUT));

  mem_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane_align (
    .func3    (func3),
    .addr_lo  (addr[1:0]),
    .is_store (MemWrite),
    .wr_data  (wr_data),
    .rdata    (mem_rdata),
    .be       (lane_be),
    .wdata    (mem_wdata),
    .load_data(load_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        if (mem_ready) begin
          state_d = StDone;
          if (MemRead) rd_data_d = load_data;
        end else begin
          if (cnt_q != CntW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
          if (cnt_q >= CntW'(TIMEOUT - 1)) begin
            state_d = StDone;
            if (MemRead) rd_data_d = '0;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign mem_req    = in_req;
  assign mem_we     = in_req & MemWrite;
  assign mem_be     = in_req ? lane_be : 4'b0000;
  assign mem_addr   = {addr[DM_ADDRESS-1:2], 2'b00};
  assign rd_data    = rd_data_q;
  assign mem_stall  = ~reset & (start | in_req);
  assign access_err = ~reset & (((state_q == StIdle) & req_any & ~legal) | timed_out);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: driver pushes expected responses from a
// reference model, a negedge monitor pops and compares as the DUT completes accesses.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    bit          to;
  } txn_t;

  typedef struct {
    bit          mem;
    logic [8:0]  maddr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          err;
    int          stalls;
    int          reqs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [2:0]  func3;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] rd_data;
  logic        mem_stall, access_err;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_W    (32),
    .DM_ADDRESS(9),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .wr_data   (wr_data),
    .func3     (func3),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .rd_data   (rd_data),
    .mem_stall (mem_stall),
    .access_err(access_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: what a well-behaved unit must do for one access, from the rules.
  function automatic exp_t model(input txn_t t, input logic [31:0] cur);
    exp_t e;
    int sz, off, bits;
    logic [31:0] v, mask;
    bit f3_ok;
    off   = int'(t.addr[1:0]);
    sz    = 1 << t.f3[1:0];
    f3_ok = t.rd ? (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (t.f3 <= 3'd2);
    e.mem    = (t.rd != t.wr) && f3_ok && (off % sz == 0);
    e.rd     = cur;
    e.err    = !e.mem;
    e.stalls = 0;
    e.reqs   = 0;
    e.maddr  = {t.addr[8:2], 2'b00};
    e.we     = t.wr;
    e.be     = 4'h0;
    e.wdata  = 32'h0;
    if (!e.mem) return e;
    e.reqs   = t.to ? TIMEOUT : t.lat + 1;
    e.stalls = e.reqs + 1;
    e.err    = t.to;
    if (t.wr) begin
      e.be = 4'((1 << sz) - 1);
      e.be = e.be << off;
      case (sz)
        1:       e.wdata = {4{t.wdata[7:0]}};
        2:       e.wdata = {2{t.wdata[15:0]}};
        default: e.wdata = t.wdata;
      endcase
    end else begin
      e.be = 4'hF;
      bits = 8 * sz;
      mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
      v    = (t.rdata >> (8 * off)) & mask;
      if (!t.f3[2] && bits < 32 && v[bits-1]) v = v | ~mask;
      e.rd = t.to ? 32'h0 : v;
    end
    return e;
  endfunction

  function automatic txn_t mk(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [8:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int lat, input bit to);
    txn_t t;
    t.rd = rd; t.wr = wr; t.f3 = f3; t.addr = a;
    t.wdata = wd; t.rdata = rdat; t.lat = lat; t.to = to;
    return t;
  endfunction

  task automatic idle_inputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    mem_ready = 1'b0;
  endtask

  // Presents one access and plays the memory side until the stall releases.
  task automatic run_txn(input txn_t t, input exp_t e);
    int k, n;
    @(posedge clk); #1;
    exp_q.push_back(e);
    model_rd  = e.rd;
    MemRead   = t.rd;
    MemWrite  = t.wr;
    func3     = t.f3;
    addr      = t.addr;
    wr_data   = t.wdata;
    mem_ready = 1'b0;
    if (!e.mem) begin
      @(posedge clk); #1;
      idle_inputs();
      return;
    end
    k = 0;
    n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (!t.to && k == t.lat) begin
          mem_ready = 1'b1;
          mem_rdata = t.rdata;
        end
        k++;
      end
      if (!mem_stall) break;
      if (n > TIMEOUT + 10) begin
        check("stall_release_bound", 32'(n), 32'(TIMEOUT + 10));
        break;
      end
    end
    idle_inputs();
  endtask

  // Monitor: bus checks on accepted requests, result checks when an access completes.
  initial begin : monitor
    bit prev;
    int sc, rc;
    exp_t e;
    prev = 0; sc = 0; rc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 0; sc = 0; rc = 0;
      end else begin
        if (mem_stall) sc++;
        if (mem_req) rc++;
        if (mem_req && mem_ready) begin
          if (exp_q.size() == 0 || !exp_q[0].mem) begin
            check("unexpected_mem_req", {31'b0, mem_req}, 32'h0);
          end else begin
            check("mem_addr", {23'b0, mem_addr}, {23'b0, exp_q[0].maddr});
            check("mem_be", {28'b0, mem_be}, {28'b0, exp_q[0].be});
            check("mem_we", {31'b0, mem_we}, {31'b0, exp_q[0].we});
            if (exp_q[0].we) check("mem_wdata", mem_wdata, exp_q[0].wdata);
          end
        end
        if ((prev && !mem_stall) || (!prev && !mem_stall && access_err)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", {31'b0, access_err}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("rd_data", rd_data, e.rd);
            check("access_err", {31'b0, access_err}, {31'b0, e.err});
            check("stall_cycles", 32'(sc), 32'(e.stalls));
            check("req_cycles", 32'(rc), 32'(e.reqs));
          end
          sc = 0;
          rc = 0;
        end
        prev = mem_stall;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
    check({tag, "_mem_be"}, {28'b0, mem_be}, 32'h0);
    check({tag, "_access_err"}, {31'b0, access_err}, 32'h0);
    check({tag, "_mem_stall"}, {31'b0, mem_stall}, 32'h0);
    check({tag, "_rd_data"}, rd_data, 32'h0);
  endtask

  initial begin : stim
    txn_t t;
    exp_t e;
    int r;
    reset = 1'b1;
    idle_inputs();
    addr = '0; wr_data = '0; func3 = '0; mem_rdata = '0;
    model_rd = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases with hand-derived expectations.
    t = mk(1, 0, 3'b010, 9'h008, 32'h0, 32'hDEADBEEF, 0, 0);
    e = model(t, model_rd); e.rd = 32'hDEADBEEF; e.stalls = 2; e.be = 4'hF;
    run_txn(t, e);
    t = mk(1, 0, 3'b000, 9'h00B, 32'h0, 32'h80FF1234, 1, 0);
    e = model(t, model_rd); e.rd = 32'hFFFFFF80;
    run_txn(t, e);
    t = mk(1, 0, 3'b100, 9'h00B, 32'h0, 32'h80FF1234, 0, 0);
    e = model(t, model_rd); e.rd = 32'h00000080;
    run_txn(t, e);
    t = mk(1, 0, 3'b001, 9'h002, 32'h0, 32'h80FF1234, 2, 0);
    e = model(t, model_rd); e.rd = 32'hFFFF80FF;
    run_txn(t, e);
    t = mk(0, 1, 3'b000, 9'h005, 32'h000000A5, 32'h0, 0, 0);
    e = model(t, model_rd);
    e.maddr = 9'h004; e.be = 4'b0010; e.wdata = 32'hA5A5A5A5; e.we = 1; e.rd = 32'hFFFF80FF;
    run_txn(t, e);
    t = mk(0, 1, 3'b001, 9'h006, 32'h1234BEEF, 32'h0, 1, 0);
    e = model(t, model_rd); e.be = 4'b1100; e.wdata = 32'hBEEFBEEF;
    run_txn(t, e);
    t = mk(1, 0, 3'b010, 9'h006, 32'h0, 32'h11111111, 0, 0);
    e = model(t, model_rd); e.err = 1; e.rd = 32'hFFFF80FF; e.stalls = 0;
    run_txn(t, e);
    t = mk(1, 1, 3'b010, 9'h008, 32'h0, 32'h11111111, 0, 0);
    e = model(t, model_rd); e.err = 1;
    run_txn(t, e);
    t = mk(1, 0, 3'b010, 9'h010, 32'h0, 32'h55555555, 0, 1);
    e = model(t, model_rd); e.reqs = 16; e.stalls = 17; e.err = 1; e.rd = 32'h0;
    run_txn(t, e);

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      t.rd = (r < 9) || (r >= 18);
      t.wr = (r >= 9);
      if ($urandom_range(0, 4) != 0) begin
        r = $urandom_range(0, 4);
        t.f3 = (r < 3) ? 3'(r) : ((r == 3) ? 3'b100 : 3'b101);
      end else begin
        t.f3 = 3'($urandom_range(0, 7));
      end
      t.addr = 9'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (t.f3[1:0] == 2'b01) t.addr[0] = 1'b0;
        if (t.f3[1:0] == 2'b10) t.addr[1:0] = 2'b00;
      end
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.lat   = $urandom_range(0, 3);
      t.to    = ($urandom_range(0, 24) == 0);
      e = model(t, model_rd);
      run_txn(t, e);
    end

    // Reset on the third REQ cycle, then a late mem_ready that must be ignored.
    t = mk(1, 0, 3'b010, 9'h020, 32'h0, 32'h12345678, 0, 0);
    run_txn(t, model(t, model_rd));
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; func3 = 3'b010; addr = 9'h010;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    MemRead = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check_reset_outputs("rst_in_req");
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("rst_rd_data_after_ready", rd_data, 32'h0);
    check("rst_no_stall_after_ready", {31'b0, mem_stall}, 32'h0);
    model_rd = 32'h0;

    t = mk(1, 0, 3'b101, 9'h01E, 32'h0, 32'h9ABC0000, 1, 0);
    run_txn(t, model(t, model_rd));

    repeat (4) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
